valid_ready_pipe: RTL and testbench
===================================

// Module: valid_ready_pipe
// PURPOSE
//   Parametrised multi-stage register pipeline with a valid/ready handshake on both sides.
//   Next generation of the single-bit D flip-flop: WIDTH-bit data, DEPTH stages, per-stage valid.
//   Bubble collapsing: an empty stage accepts data even while downstream stalls.
//   Sits between producer/consumer blocks as a timing-cut / elastic delay line.
// PARAMETERS
//   WIDTH    8   data bits per stage (>=1)
//   DEPTH    4   number of register stages (>=1)
// PORTS
//   clk        input   1           rising-edge clock; sole clock domain
//   reset      input   1           synchronous, active-high reset
//   flush      input   1           synchronous clear of all stage valid bits
//   in_valid   input   1           producer offers in_data this cycle
//   in_ready   output  1           pipe accepts in_data this cycle
//   in_data    input   WIDTH       producer data
//   out_valid  output  1           out_data holds a valid word
//   out_ready  input   1           consumer takes out_data this cycle
//   out_data   output  WIDTH       data of last stage (DEPTH-1)
//   occupancy  output  $clog2(DEPTH+1)   valid-stage count (only with PIPE_OCCUPANCY_EN)
// BEHAVIOUR
//   - Interface: one clock (clk); reset is synchronous and active-high (reset).
//   - State per stage i (0..DEPTH-1): vld[i], dat[i][WIDTH-1:0]. Stage 0 faces input, DEPTH-1 output.
//   - Reset (reset=1 at posedge): all vld=0, all dat=0 -> out_valid=0, out_data=0, occupancy=0.
//     reset has priority over flush and all handshakes; in_ready=0 while reset=1.
//   - Advance rule: adv[DEPTH-1] = !vld[DEPTH-1] | out_ready; adv[i] = !vld[i] | adv[i+1].
//   - in_ready = adv[0] & !flush & !reset (combinational, no combinational path from in_valid).
//   - Transfer in: in_valid & in_ready -> stage0 loads in_data, vld[0]=1 next cycle.
//     adv[0] & !in_valid -> vld[0]=0 (bubble inserted).
//   - Stage i>0 with adv[i]=1: dat[i]<=dat[i-1], vld[i]<=vld[i-1]. adv[i]=0: hold.
//   - Transfer out: out_valid & out_ready. out_valid=vld[DEPTH-1], out_data=dat[DEPTH-1].
//   - Latency: word accepted at cycle N appears with out_valid=1 at cycle N+DEPTH (no stalls).
//   - Throughput: 1 word/cycle with out_ready held high; no bubbles added by the pipe.
//   - Stall: out_ready=0 -> last stage holds; upstream stages fill bubbles; in_ready drops
//     only when all DEPTH stages valid. Max occupancy = DEPTH words, none lost or duplicated.
//   - Full + out_ready=1 + in_valid=1 same cycle: simultaneous in/out transfer, occupancy unchanged.
//   - flush=1: next cycle all vld=0; dat unchanged; no input accepted that cycle;
//     words present are dropped even if out_ready=1 (the out transfer in that cycle still counts).
//   - out_data stable and out_valid held while out_valid & !out_ready (AXI-style rule).
//   - DEPTH=1: single register with in_ready = !vld[0] | out_ready.
// CONFIGURATION
//   PIPE_OCCUPANCY_EN defined: occupancy port present = popcount(vld), registered-state derived,
//     updates same cycle as vld; 0 after reset/flush.
//   PIPE_OCCUPANCY_EN undefined: occupancy port and counter logic absent; all else identical.
// TESTING
//   1 reset=1 two cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0; occupancy=0.
//   2 WIDTH=8,DEPTH=4, out_ready=1, stream 0x01..0x10 back-to-back -> 0x01 out 4 cycles after
//     accept, then one word/cycle in order, in_ready never drops.
//   3 out_ready=0, push 0xA1,0xA2,0xA3,0xA4,0xA5 -> first four accepted, in_ready=0 at fifth,
//     occupancy=4; release out_ready -> A1..A5 delivered in order, no loss/duplication.
//   4 out_ready=0, single word 0x5C, then in_valid=1 0x5D two cycles later -> 0x5D collapses
//     bubble, lands in stage2 behind 0x5C; occupancy=2.
//   5 pipe holding 3 words, assert flush one cycle with in_valid=1 data 0xEE -> in_ready=0,
//     next cycle out_valid=0, occupancy=0, 0xEE never emitted.
//   6 full pipe, out_ready=1 and in_valid=1 every cycle for 20 cycles -> occupancy constant 4,
//     outputs match scoreboard; assert reset mid-stream -> next cycle all outputs zero.

Source files
------------

// File: rtl/valid_ready_pipe.sv
// ============================================================================
// Module   : valid_ready_pipe
// Brief    : WIDTH-bit, DEPTH-stage valid/ready register pipeline with bubble
//            collapsing. Optional macro PIPE_OCCUPANCY_EN adds an occupancy port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module valid_ready_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data
`ifdef PIPE_OCCUPANCY_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];
   logic [DEPTH-1:0] adv;

   // Stage i may advance when any stage from i to the output is empty, or the
   // consumer is taking the last word; this is the unrolled adv[i] chain.
   for (genvar i = 0; i < DEPTH; i++) begin : g_adv
      assign adv[i] = out_ready | ~(&vld[DEPTH-1:i]);
   end

   assign in_ready  = adv[0] & ~flush & ~reset;
   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dat[i] <= '0;
         end
      end else if (flush) begin
         // Words in flight are dropped; data registers keep their contents.
         vld <= '0;
      end else begin
         if (adv[0]) begin
            vld[0] <= in_valid;
            if (in_valid) begin
               dat[0] <= in_data;
            end
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
               vld[i] <= vld[i-1];
               dat[i] <= dat[i-1];
            end
         end
      end
   end

`ifdef PIPE_OCCUPANCY_EN
   localparam int OCC_W = $clog2(DEPTH+1);

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + OCC_W'(vld[i]);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_valid_ready_pipe.sv
// ============================================================================
// Module   : tb_valid_ready_pipe
// Brief    : Directed self-checking bench for valid_ready_pipe (WIDTH=8, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_valid_ready_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
`ifdef PIPE_OCCUPANCY_EN
   logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   valid_ready_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_OCCUPANCY_EN
      ,
      .occupancy (occupancy)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic check_occ(input string tag, input int exp);
`ifdef PIPE_OCCUPANCY_EN
      check(tag, 32'(occupancy), 32'(exp));
`endif
   endtask

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] words [24];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;

      // Reset held two cycles with a valid offer
      for (int k = 0; k < 2; k++) begin
         cyc();
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_data",  32'(out_data),  32'd0);
         check("rst_in_ready",  32'(in_ready),  32'd0);
         check_occ("rst_occ", 0);
      end
      reset = 1'b0; in_valid = 1'b0;
      cyc();

      // Back-to-back stream 0x01..0x10, four-cycle latency
      for (int t = 0; t < 22; t++) begin
         in_valid = (t < 16);
         in_data  = 8'(t + 1);
         #1;
         if (t < 16) check("stream_in_ready", 32'(in_ready), 32'd1);
         check("stream_out_valid", 32'(out_valid), 32'((t >= 4) && (t < 20)));
         if (t >= 4 && t < 20) check("stream_out_data", 32'(out_data), 32'(t - 3));
         cyc();
      end
      in_valid = 1'b0;

      // Stall: fill with A1..A4, A5 refused, then drain in order
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = 8'hA1 + 8'(k);
         #1;
         check("stall_in_ready_fill", 32'(in_ready), 32'd1);
         check("stall_out_valid_fill", 32'(out_valid), 32'd0);
         cyc();
      end
      in_valid = 1'b1; in_data = 8'hA5;
      #1;
      check("stall_in_ready_full", 32'(in_ready), 32'd0);
      check("stall_out_data_full", 32'(out_data), 32'hA1);
      check_occ("stall_occ_full", 4);
      cyc();
      out_ready = 1'b1;
      #1;
      check("stall_in_ready_release", 32'(in_ready), 32'd1);
      check("stall_out_a1", 32'(out_data), 32'hA1);
      check_occ("stall_occ_swap", 4);
      cyc();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("stall_drain_valid", 32'(out_valid), 32'd1);
         check("stall_drain_data", 32'(out_data), 32'(8'hA2 + 8'(k)));
         cyc();
      end
      check("stall_empty_valid", 32'(out_valid), 32'd0);
      check_occ("stall_occ_empty", 0);

      // Bubble collapse: 0x5C, gap, 0x5D with output stalled
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h5C; cyc();
      in_valid = 1'b0; cyc();
      in_valid = 1'b1; in_data = 8'h5D;
      #1;
      check("bubble_in_ready", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      repeat (3) cyc();
      check("bubble_out_valid", 32'(out_valid), 32'd1);
      check("bubble_out_data", 32'(out_data), 32'h5C);
      check("bubble_in_ready_after", 32'(in_ready), 32'd1);
      check_occ("bubble_occ", 2);
      out_ready = 1'b1;
      cyc();
      check("bubble_second_valid", 32'(out_valid), 32'd1);
      check("bubble_second_data", 32'(out_data), 32'h5D);
      cyc();
      check("bubble_drained", 32'(out_valid), 32'd0);

      // Flush with three words held and 0xEE offered
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 8'hB1 + 8'(k); cyc();
      end
      in_valid = 1'b0; cyc();
      flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      #1;
      check("flush_in_ready", 32'(in_ready), 32'd0);
      check("flush_pre_data", 32'(out_data), 32'hB1);
      check_occ("flush_pre_occ", 3);
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_data_kept", 32'(out_data), 32'hB1);
      check_occ("flush_occ", 0);
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         check("flush_no_ee", 32'(out_valid), 32'd0);
      end

      // Full pipe streaming 20 cycles, then reset mid-stream
      for (int k = 0; k < 4; k++) words[k] = 8'hC0 + 8'(k);
      for (int k = 0; k < 20; k++) words[k+4] = 8'h30 + 8'(k);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = words[k]; cyc();
      end
      out_ready = 1'b1;
      for (int j = 0; j < 20; j++) begin
         in_valid = 1'b1; in_data = words[j+4];
         #1;
         check("full_in_ready", 32'(in_ready), 32'd1);
         check("full_out_data", 32'(out_data), 32'(words[j]));
         check_occ("full_occ", 4);
         cyc();
      end
      reset = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      cyc();
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check_occ("midrst_occ", 0);
      reset = 1'b0; in_valid = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
